// File: rtl/camera_capture_adaptive.sv
// OV7670 capture and binarise stage in the cam_pclk domain, feeding the frame buffer write port.
// The threshold is either fixed or adapted from the previous frame's luma midpoint plus an offset.
module camera_capture_adaptive #(
  parameter int IMG_W         = 320,
  parameter int IMG_H         = 240,
  parameter int ADDR_W        = 17,
  parameter int BYTES_PER_PIX = 2,
  parameter int LUMA_BYTE     = 0,
  parameter int THR_INIT      = 128,
  parameter int MIN_CONTRAST  = 32
) (
  input  logic              cam_pclk,
  input  logic              nreset,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              thr_mode,
  input  logic [7:0]        thr_fixed,
  input  logic [7:0]        thr_offset,
  input  logic              invert,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              wr_en,
  output logic              frame_done,
  output logic              in_frame,
  output logic [7:0]        thr_active,
  output logic              frame_err
);

  localparam int COL_W = $clog2(IMG_W + 1);
  localparam int ROW_W = $clog2(IMG_H + 1);
  localparam int PH_W  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;

  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IMG_W);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(IMG_H);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BYTES_PER_PIX - 1);
  localparam logic [PH_W-1:0]  LUMA_IDX = PH_W'(LUMA_BYTE);
  localparam logic [8:0]       MIN_C    = 9'(MIN_CONTRAST);
  localparam logic [7:0]       THR_RST  = 8'(THR_INIT);

  typedef enum logic [1:0] {
    WAIT_BLANK,
    WAIT_START,
    ACTIVE
  } state_t;

  state_t state, state_n;

  logic              vsync_r, vsync_q, href_r, href_q;
  logic [7:0]        data_r;
  logic [ROW_W-1:0]  row, row_n;
  logic [COL_W-1:0]  col, col_n;
  logic [PH_W-1:0]   phase, phase_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              err, err_n;
  logic [7:0]        luma_min, luma_max, min_n, max_n;
  logic              mode_l, mode_n, invert_l, invert_n;
  logic [7:0]        offset_l, offset_n;
  logic [7:0]        thr_next, thr_next_n, thr_active_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic              wr_data_n, wr_en_n, frame_done_n, frame_err_n;

  logic              vsync_rise, vsync_fall, href_fall, line_end, in_win;
  logic [7:0]        mid;
  logic signed [9:0] thr_sum;

  assign vsync_rise = vsync_r & ~vsync_q;
  assign vsync_fall = ~vsync_r & vsync_q;
  assign href_fall  = ~href_r & href_q;
  assign in_win     = (row < ROW_MAX) && (col < COL_MAX);
  assign in_frame   = (state == ACTIVE);

  always_comb begin
    state_n      = state;
    row_n        = row;
    col_n        = col;
    phase_n      = phase;
    addr_n       = addr;
    err_n        = err;
    min_n        = luma_min;
    max_n        = luma_max;
    mode_n       = mode_l;
    invert_n     = invert_l;
    offset_n     = offset_l;
    thr_next_n   = thr_next;
    thr_active_n = thr_active;
    wr_addr_n    = wr_addr;
    wr_data_n    = wr_data;
    wr_en_n      = 1'b0;
    frame_done_n = 1'b0;
    frame_err_n  = frame_err;
    line_end     = 1'b0;
    mid          = '0;
    thr_sum      = '0;

    case (state)
      WAIT_BLANK: begin
        if (vsync_r) state_n = WAIT_START;
      end

      WAIT_START: begin
        if (vsync_fall) begin
          state_n      = ACTIVE;
          mode_n       = thr_mode;
          offset_n     = thr_offset;
          invert_n     = invert;
          thr_active_n = thr_mode ? thr_next : thr_fixed;
          row_n        = '0;
          col_n        = '0;
          phase_n      = '0;
          addr_n       = '0;
          err_n        = 1'b0;
          min_n        = '1;
          max_n        = '0;
        end
      end

      ACTIVE: begin
        if (href_r) begin
          phase_n = (phase == PH_LAST) ? '0 : phase + 1'b1;
          if (phase == LUMA_IDX) begin
            if (in_win) begin
              wr_en_n   = 1'b1;
              wr_addr_n = addr;
              wr_data_n = (data_r >= thr_active) ^ invert_l;
              addr_n    = addr + 1'b1;
              col_n     = col + 1'b1;
              if (data_r < luma_min) min_n = data_r;
              if (data_r > luma_max) max_n = data_r;
            end else begin
              err_n = 1'b1;
            end
          end
        end

        // A vsync rise with href still high closes the line early and is always an error
        line_end = href_fall | (vsync_rise & href_r);
        if (line_end) begin
          if ((col != COL_MAX) || vsync_rise) err_n = 1'b1;
          row_n   = (row == ROW_MAX) ? row : row + 1'b1;
          col_n   = '0;
          phase_n = '0;
        end

        if (vsync_rise) begin
          state_n      = WAIT_START;
          frame_done_n = 1'b1;
          frame_err_n  = err_n | (row_n != ROW_MAX);
          mid          = 8'((9'(min_n) + 9'(max_n)) >> 1);
          thr_sum      = $signed({2'b00, mid}) + $signed({{2{offset_l[7]}}, offset_l});
          if (mode_l && (max_n >= min_n) && (9'(max_n - min_n) >= MIN_C)) begin
            if (thr_sum < 0)
              thr_next_n = 8'd0;
            else if (thr_sum > 10'sd255)
              thr_next_n = 8'd255;
            else
              thr_next_n = thr_sum[7:0];
          end
        end
      end

      default: state_n = WAIT_BLANK;
    endcase
  end

  always_ff @(posedge cam_pclk) begin
    if (!nreset) begin
      state      <= WAIT_BLANK;
      vsync_r    <= 1'b0;
      vsync_q    <= 1'b0;
      href_r     <= 1'b0;
      href_q     <= 1'b0;
      data_r     <= '0;
      row        <= '0;
      col        <= '0;
      phase      <= '0;
      addr       <= '0;
      err        <= 1'b0;
      luma_min   <= '0;
      luma_max   <= '0;
      mode_l     <= 1'b0;
      invert_l   <= 1'b0;
      offset_l   <= '0;
      thr_next   <= THR_RST;
      thr_active <= THR_RST;
      wr_addr    <= '0;
      wr_data    <= 1'b0;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      vsync_r    <= cam_vsync;
      vsync_q    <= vsync_r;
      href_r     <= cam_href;
      href_q     <= href_r;
      data_r     <= cam_data;
      row        <= row_n;
      col        <= col_n;
      phase      <= phase_n;
      addr       <= addr_n;
      err        <= err_n;
      luma_min   <= min_n;
      luma_max   <= max_n;
      mode_l     <= mode_n;
      invert_l   <= invert_n;
      offset_l   <= offset_n;
      thr_next   <= thr_next_n;
      thr_active <= thr_active_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      wr_en      <= wr_en_n;
      frame_done <= frame_done_n;
      frame_err  <= frame_err_n;
    end
  end

endmodule

// File: tb/tb_camera_capture_adaptive.sv
// Scoreboard bench for camera_capture_adaptive on a 4x3 image, 2 bytes per pixel, luma at byte 0.
// Stimulus tasks queue expected writes and frame results; a negedge monitor pops and compares.
module tb_camera_capture_adaptive;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;

  logic          cam_pclk = 1'b0;
  logic          nreset = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_data = '0;
  logic          thr_mode = 1'b0;
  logic [7:0]    thr_fixed = 8'd100;
  logic [7:0]    thr_offset = 8'd0;
  logic          invert = 1'b0;
  logic [AW-1:0] wr_addr;
  logic          wr_data, wr_en, frame_done, in_frame, frame_err;
  logic [7:0]    thr_active;

  always #5 cam_pclk = ~cam_pclk;

  camera_capture_adaptive #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .BYTES_PER_PIX(2),
    .LUMA_BYTE(0), .THR_INIT(128), .MIN_CONTRAST(32)
  ) dut (
    .cam_pclk(cam_pclk), .nreset(nreset), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .thr_mode(thr_mode), .thr_fixed(thr_fixed),
    .thr_offset(thr_offset), .invert(invert), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .frame_done(frame_done), .in_frame(in_frame),
    .thr_active(thr_active), .frame_err(frame_err)
  );

  typedef struct packed {logic [AW-1:0] addr; logic data;} wexp_t;
  typedef struct packed {logic err; logic [7:0] thr;} fexp_t;

  wexp_t wq[$];
  fexp_t fq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge cam_pclk) begin : monitor
    wexp_t we;
    fexp_t fe;
    if (wr_en === 1'b1) begin
      if (wq.size() == 0) check("unexpected_wr_en", 1, 0);
      else begin
        we = wq.pop_front();
        check("wr_addr", int'(wr_addr), int'(we.addr));
        check("wr_data", int'(wr_data), int'(we.data));
      end
    end
    if (frame_done === 1'b1) begin
      if (fq.size() == 0) check("unexpected_frame_done", 1, 0);
      else begin
        fe = fq.pop_front();
        check("frame_err", int'(frame_err), int'(fe.err));
        check("thr_active", int'(thr_active), int'(fe.thr));
      end
    end
  end

  task automatic push_w(input int a, input bit d);
    wexp_t e;
    e.addr = AW'(a);
    e.data = d;
    wq.push_back(e);
  endtask

  task automatic push_f(input bit err, input logic [7:0] thr);
    fexp_t e;
    e.err = err;
    e.thr = thr;
    fq.push_back(e);
  endtask

  task automatic send_pix(input logic [7:0] l, input bit we, input int a, input bit d);
    if (we) push_w(a, d);
    @(negedge cam_pclk); cam_href = 1'b1; cam_data = l;
    @(negedge cam_pclk); cam_data = ~l;
  endtask

  task automatic end_line();
    @(negedge cam_pclk); cam_href = 1'b0;
    @(negedge cam_pclk);
  endtask

  task automatic frame_begin();
    @(negedge cam_pclk); cam_vsync = 1'b1; cam_href = 1'b0;
    repeat (3) @(negedge cam_pclk);
    cam_vsync = 1'b0;
    repeat (3) @(negedge cam_pclk);
    check("in_frame", int'(in_frame), 1);
  endtask

  task automatic frame_end(input bit err, input logic [7:0] thr);
    push_f(err, thr);
    @(negedge cam_pclk); cam_vsync = 1'b1; cam_href = 1'b0;
    repeat (3) @(negedge cam_pclk);
  endtask

  // Clean 4x3 frame, even pixels luma a, odd pixels luma b
  task automatic std_frame(input logic [7:0] a, input logic [7:0] b, input bit da, input bit db,
                           input bit err, input logic [7:0] thr);
    frame_begin();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++)
        send_pix((c % 2 == 0) ? a : b, 1'b1, r * W + c, (c % 2 == 0) ? da : db);
      end_line();
    end
    frame_end(err, thr);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
    repeat (3) @(negedge cam_pclk);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_in_frame", int'(in_frame), 0);
    check("rst_thr_active", int'(thr_active), 128);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    nreset = 1'b1;

    // Fixed threshold 100 on a clipped ramp
    thr_mode = 1'b0; thr_fixed = 8'd100; invert = 1'b0;
    frame_begin();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        l = (r * W + c) * 50;
        if (l > 255) l = 255;
        send_pix(8'(l), 1'b1, r * W + c, l >= 100);
      end
      end_line();
    end
    frame_end(1'b0, 8'd100);

    // Adaptive: midpoint 120, low-contrast hold, then negative offset to 112
    thr_mode = 1'b1; thr_offset = 8'd0;
    std_frame(8'd20, 8'd220, 1'b0, 1'b1, 1'b0, 8'd128);
    std_frame(8'd119, 8'd121, 1'b0, 1'b1, 1'b0, 8'd120);
    thr_offset = 8'hF8;
    std_frame(8'd20, 8'd220, 1'b0, 1'b1, 1'b0, 8'd120);
    std_frame(8'd111, 8'd112, 1'b0, 1'b1, 1'b0, 8'd112);

    // Reset restores THR_INIT; low-contrast frame keeps it
    @(negedge cam_pclk); nreset = 1'b0;
    repeat (2) @(negedge cam_pclk);
    check("rst2_thr_active", int'(thr_active), 128);
    check("rst2_in_frame", int'(in_frame), 0);
    nreset = 1'b1; thr_offset = 8'd0;
    frame_begin();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) send_pix(8'(100 + r * W + c), 1'b1, r * W + c, 1'b0);
      end_line();
    end
    frame_end(1'b0, 8'd128);
    std_frame(8'd127, 8'd128, 1'b0, 1'b1, 1'b0, 8'd128);

    // Geometry: overlong line, then short frame, then clean frame
    thr_mode = 1'b0; thr_fixed = 8'd100;
    frame_begin();
    for (int c = 0; c < W + 2; c++)
      send_pix((c % 2 == 0) ? 8'd50 : 8'd150, c < W, c, c % 2 == 1);
    end_line();
    for (int r = 1; r < H; r++) begin
      for (int c = 0; c < W; c++) send_pix((c % 2 == 0) ? 8'd50 : 8'd150, 1'b1, r * W + c, c % 2 == 1);
      end_line();
    end
    frame_end(1'b1, 8'd100);
    frame_begin();
    for (int r = 0; r < H - 1; r++) begin
      for (int c = 0; c < W; c++) send_pix((c % 2 == 0) ? 8'd50 : 8'd150, 1'b1, r * W + c, c % 2 == 1);
      end_line();
    end
    frame_end(1'b1, 8'd100);
    std_frame(8'd50, 8'd150, 1'b0, 1'b1, 1'b0, 8'd100);

    // Partial last line: final luma byte lands with the vsync rise, write and frame_done together
    frame_begin();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r < H - 1 || c < W - 1) send_pix((c % 2 == 0) ? 8'd50 : 8'd150, 1'b1, r * W + c, c % 2 == 1);
      end
      if (r < H - 1) end_line();
    end
    push_w(W * H - 1, 1'b1);
    push_f(1'b1, 8'd100);
    @(negedge cam_pclk); cam_vsync = 1'b1; cam_href = 1'b1; cam_data = 8'd150;
    @(negedge cam_pclk); cam_data = 8'd105;
    @(negedge cam_pclk); cam_href = 1'b0;
    repeat (3) @(negedge cam_pclk);

    // One-cycle reset mid-line discards the frame
    frame_begin();
    send_pix(8'd50, 1'b1, 0, 1'b0);
    send_pix(8'd150, 1'b1, 1, 1'b1);
    @(negedge cam_pclk); nreset = 1'b0; cam_data = 8'd150;
    @(negedge cam_pclk); nreset = 1'b1; cam_data = 8'd77;
    send_pix(8'd150, 1'b0, 0, 1'b0);
    send_pix(8'd150, 1'b0, 0, 1'b0);
    end_line();
    repeat (4) @(negedge cam_pclk);
    check("rst3_thr_active", int'(thr_active), 128);
    check("rst3_in_frame", int'(in_frame), 0);
    thr_mode = 1'b1;
    std_frame(8'd50, 8'd150, 1'b0, 1'b1, 1'b0, 8'd128);

    // invert and thr_fixed changed mid-frame take effect only next frame
    thr_mode = 1'b0; thr_fixed = 8'd100; invert = 1'b0;
    frame_begin();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) send_pix((c % 2 == 0) ? 8'd50 : 8'd150, 1'b1, r * W + c, c % 2 == 1);
      end_line();
      if (r == 0) begin
        invert = 1'b1;
        thr_fixed = 8'd200;
      end
    end
    frame_end(1'b0, 8'd100);
    std_frame(8'd50, 8'd250, 1'b1, 1'b0, 1'b0, 8'd200);

    for (int i = 0; i < 100 && (wq.size() != 0 || fq.size() != 0); i++) @(negedge cam_pclk);
    check("write_queue_drained", wq.size(), 0);
    check("frame_queue_drained", fq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
